// File: rtl/accumulator_pkg.sv
// Shared types and helpers for the output-side accumulator bank.
package accumulator_pkg;

    localparam int PSW_DEF       = 19;
    localparam int ACC_WIDTH_DEF = 23;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] sum;
    } sat_res_t;

    // Signed add clamped to a width-bit two's complement range.
    // Operands arrive sign-extended to 64 bits; width must stay below 64.
    function automatic sat_res_t sat_add(input logic signed [63:0] acc,
                                         input logic signed [63:0] psum,
                                         input int                 width);
        logic signed [63:0] lim_max;
        logic signed [63:0] lim_min;
        logic signed [63:0] raw;
        sat_res_t           res;
        lim_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        lim_min = -(64'sd1 <<< (width - 1));
        raw     = acc + psum;
        res.ovf = 1'b0;
        res.sum = raw;
        if (raw > lim_max) begin
            res.sum = lim_max;
            res.ovf = 1'b1;
        end else if (raw < lim_min) begin
            res.sum = lim_min;
            res.ovf = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/accumulator_column.sv
// One column of the bank: word memory, overwrite/saturating-accumulate
// write path, read-first registered read and a sticky saturation flag.
module accumulator_column
    import accumulator_pkg::*;
#(
    parameter int PSW        = PSW_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic                  i_acc_mode,
    input  logic [PSW-1:0]        i_psum,
    input  logic                  i_clr_en,
    input  logic [ADDR_WIDTH-1:0] i_clr_addr,
    input  logic                  i_sat_clr,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [ACC_WIDTH-1:0]  o_rd_data,
    output logic                  o_sat
);

    logic [ACC_WIDTH-1:0] r_mem [DEPTH];
    logic [ACC_WIDTH-1:0] r_rd_data;
    logic                 r_sat;

    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_do_wr;
    logic [ACC_WIDTH-1:0] w_cur;
    logic [ACC_WIDTH-1:0] w_wr_data;
    logic signed [63:0]   w_cur_ext;
    logic signed [63:0]   w_psum_ext;
    sat_res_t             w_sat;
    logic                 w_ovf;
    logic                 w_unused;

    assign w_wr_in_range = int'(i_wr_addr) < DEPTH;
    assign w_rd_in_range = int'(i_rd_addr) < DEPTH;
    assign w_do_wr       = i_wr_en & w_wr_in_range;

    // Combinational read-modify path so same-address writes chain each cycle.
    always_comb begin
        w_cur = '0;
        if (w_wr_in_range)
            w_cur = r_mem[i_wr_addr];
        w_cur_ext  = 64'(signed'(w_cur));
        w_psum_ext = 64'(signed'(i_psum));
        w_sat      = sat_add(w_cur_ext, w_psum_ext, ACC_WIDTH);
        w_wr_data  = w_psum_ext[ACC_WIDTH-1:0];
        w_ovf      = 1'b0;
        if (i_acc_mode) begin
            w_wr_data = w_sat.sum[ACC_WIDTH-1:0];
            w_ovf     = w_sat.ovf;
        end
    end

    assign w_unused = ^{w_sat.sum[63:ACC_WIDTH], w_psum_ext[63:ACC_WIDTH]};

    // Memory write: clear sweep has priority over functional writes.
    always_ff @(posedge clk) begin
        if (i_clr_en)
            r_mem[i_clr_addr] <= '0;
        else if (w_do_wr)
            r_mem[i_wr_addr] <= w_wr_data;
    end

    // Registered read; samples pre-write contents and holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd_data <= '0;
        else if (i_rd_en)
            r_rd_data <= w_rd_in_range ? r_mem[i_rd_addr] : '0;
    end

    // Sticky saturation flag, cleared when a clear sweep starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat <= 1'b0;
        else if (i_sat_clr)
            r_sat <= 1'b0;
        else if (w_do_wr && w_ovf)
            r_sat <= 1'b1;
    end

    assign o_rd_data = r_rd_data;
    assign o_sat     = r_sat;

endmodule

// File: rtl/accumulator_bank.sv
// Output-side accumulator for the systolic array: skews write controls
// across columns, sequences a full-memory clear and serves registered reads.
module accumulator_bank
    import accumulator_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int ACC_WIDTH         = PARTIAL_SUM_WIDTH + 4,
    parameter int PATTERN_NUMBER    = 4,
    parameter int DEPTH             = PATTERN_NUMBER * SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   test_mode,
    input  logic                                   wr_en,
    input  logic [ADDR_WIDTH-1:0]                  wr_addr,
    input  logic                                   acc_mode,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] psum_in_flat,
    input  logic                                   clear_start,
    output logic                                   clear_busy,
    input  logic                                   rd_en,
    input  logic [ADDR_WIDTH-1:0]                  rd_addr,
    output logic                                   rd_valid,
    output logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0]     rd_data_flat,
    output logic [SYSTOLIC_SIZE-1:0]               sat_flags
);

    localparam int PSW = PARTIAL_SUM_WIDTH;
    localparam int NST = SYSTOLIC_SIZE - 1;

    logic [NST-1:0]                 r_skew_en;
    logic [NST-1:0][ADDR_WIDTH-1:0] r_skew_addr;
    logic [NST-1:0]                 r_skew_mode;

    clr_state_t                     r_state;
    logic [ADDR_WIDTH-1:0]          r_cnt;
    logic                           r_clear_busy;
    logic                           r_rd_valid;

    logic                           w_clr_go;
    logic                           w_rd_go;

    assign w_clr_go = (r_state == IDLE) && clear_start;
    assign w_rd_go  = rd_en && !r_clear_busy && !w_clr_go;

    // Skew pipeline: stage k feeds column k+1; always shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skew_en   <= '0;
            r_skew_addr <= '0;
            r_skew_mode <= '0;
        end else begin
            r_skew_en[0]   <= wr_en;
            r_skew_addr[0] <= wr_addr;
            r_skew_mode[0] <= acc_mode;
            for (int k = 1; k < NST; k++) begin
                r_skew_en[k]   <= r_skew_en[k-1];
                r_skew_addr[k] <= r_skew_addr[k-1];
                r_skew_mode[k] <= r_skew_mode[k-1];
            end
        end
    end

    // Clear sequencer: sweeps every address once, one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (clear_start) begin
                    r_state      <= CLEAR;
                    r_cnt        <= '0;
                    r_clear_busy <= 1'b1;
                end
                CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state      <= IDLE;
                        r_clear_busy <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Read valid follows accepted reads by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd_valid <= 1'b0;
        else
            r_rd_valid <= w_rd_go;
    end

    for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_col
        logic                  w_en;
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_mode;

        if (i == 0) begin : g_direct
            assign w_en   = wr_en;
            assign w_addr = wr_addr;
            assign w_mode = acc_mode;
        end else begin : g_skewed
            assign w_en   = test_mode ? wr_en    : r_skew_en[i-1];
            assign w_addr = test_mode ? wr_addr  : r_skew_addr[i-1];
            assign w_mode = test_mode ? acc_mode : r_skew_mode[i-1];
        end

        accumulator_column #(
            .PSW       (PSW),
            .ACC_WIDTH (ACC_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_col (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_en && !r_clear_busy),
            .i_wr_addr (w_addr),
            .i_acc_mode(w_mode),
            .i_psum    (psum_in_flat[i*PSW +: PSW]),
            .i_clr_en  (r_clear_busy),
            .i_clr_addr(r_cnt),
            .i_sat_clr (w_clr_go),
            .i_rd_en   (w_rd_go),
            .i_rd_addr (rd_addr),
            .o_rd_data (rd_data_flat[i*ACC_WIDTH +: ACC_WIDTH]),
            .o_sat     (sat_flags[i])
        );
    end

    assign clear_busy = r_clear_busy;
    assign rd_valid   = r_rd_valid;

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank: 4 columns, 23-bit words, 16 deep.
module tb_accumulator_bank;

    localparam int N    = 4;
    localparam int PSW  = 19;
    localparam int ACCW = 23;
    localparam int DEP  = 16;
    localparam int AW   = 4;

    logic              clk;
    logic              rst_n;
    logic              test_mode;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic              acc_mode;
    logic [PSW*N-1:0]  psum_in_flat;
    logic              clear_start;
    logic              clear_busy;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid;
    logic [ACCW*N-1:0] rd_data_flat;
    logic [N-1:0]      sat_flags;

    int n_total = 0;
    int n_pass  = 0;

    accumulator_bank #(
        .SYSTOLIC_SIZE    (N),
        .WEIGHT_WIDTH     (8),
        .ACTIVATION_WIDTH (8),
        .PARTIAL_SUM_WIDTH(PSW),
        .ACC_WIDTH        (ACCW),
        .PATTERN_NUMBER   (4),
        .DEPTH            (DEP),
        .ADDR_WIDTH       (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .test_mode   (test_mode),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .acc_mode    (acc_mode),
        .psum_in_flat(psum_in_flat),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_data_flat(rd_data_flat),
        .sat_flags   (sat_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int e0;
        int e1;
        int e2;
        int e3;
    } rd_vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_cols(input string name, input logic [ACCW*N-1:0] act,
                              input int e0, input int e1, input int e2, input int e3);
        logic [ACCW*N-1:0] exp;
        exp[0*ACCW +: ACCW] = ACCW'(e0);
        exp[1*ACCW +: ACCW] = ACCW'(e1);
        exp[2*ACCW +: ACCW] = ACCW'(e2);
        exp[3*ACCW +: ACCW] = ACCW'(e3);
        check(name, 128'(act), 128'(exp));
    endtask

    task automatic set_psum(input int a, input int b, input int c, input int d);
        psum_in_flat[0*PSW +: PSW] = PSW'(a);
        psum_in_flat[1*PSW +: PSW] = PSW'(b);
        psum_in_flat[2*PSW +: PSW] = PSW'(c);
        psum_in_flat[3*PSW +: PSW] = PSW'(d);
    endtask

    // Called at a negedge; returns the registered result one cycle later.
    task automatic do_read(input int addr, output logic [ACCW*N-1:0] data, output logic vld);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        @(negedge clk);
        rd_en = 1'b0;
        vld   = rd_valid;
        data  = rd_data_flat;
    endtask

    // Single-cycle write pulse, called at a negedge.
    task automatic do_write(input int addr, input logic mode, input int p);
        wr_en    = 1'b1;
        wr_addr  = AW'(addr);
        acc_mode = mode;
        set_psum(p, p, p, p);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        rd_vec_t           tbl[7];
        logic [ACCW*N-1:0] d;
        logic              v;
        int                cnt;

        tbl[0] = '{3, 1, 18, 35, 52};
        tbl[1] = '{2, 0, 0, 0, 0};
        tbl[2] = '{4, 0, 0, 0, 0};
        tbl[3] = '{11, 1, 2, 3, 4};
        tbl[4] = '{7, -5, -5, -5, -5};
        tbl[5] = '{10, 0, 0, 0, 0};
        tbl[6] = '{12, 0, 0, 0, 0};

        rst_n = 1'b0; test_mode = 1'b0; wr_en = 1'b0; wr_addr = '0; acc_mode = 1'b0;
        psum_in_flat = '0; clear_start = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(clear_busy), 128'(0));
        check("rst_valid", 128'(rd_valid), 128'(0));
        check("rst_sat", 128'(sat_flags), 128'(0));
        check("rst_data", 128'(rd_data_flat), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Clear sweep length and all-zero contents afterwards.
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_len", 128'(cnt), 128'(16));
        for (int a = 0; a < DEP; a++) begin
            do_read(a, d, v);
            check("zero_valid", 128'(v), 128'(1));
            check_cols("zero_data", d, 0, 0, 0, 0);
        end

        // Normal-mode skew: column i takes the psum present at cycle t+i.
        wr_en = 1'b1; wr_addr = 4'd3; acc_mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_psum(16*k + 1, 16*k + 2, 16*k + 3, 16*k + 4);
            @(negedge clk);
            wr_en = 1'b0;
        end
        set_psum(999, 999, 999, 999);
        repeat (4) @(negedge clk);

        // Test mode: every column writes in the same cycle.
        test_mode = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd11;
        for (int k = 0; k < 4; k++) begin
            set_psum(16*k + 1, 16*k + 2, 16*k + 3, 16*k + 4);
            @(negedge clk);
            wr_en = 1'b0;
        end

        // Back-to-back accumulation at addr 7.
        wr_en = 1'b1; wr_addr = 4'd7; acc_mode = 1'b1;
        set_psum(5, 5, 5, 5);
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        do_read(7, d, v);
        check("acc15_valid", 128'(v), 128'(1));
        check_cols("acc15_data", d, 15, 15, 15, 15);
        do_write(7, 1'b1, -20);

        for (int i = 0; i < 7; i++) begin
            do_read(tbl[i].addr, d, v);
            check($sformatf("tbl%0d_valid", i), 128'(v), 128'(1));
            check_cols($sformatf("tbl%0d_addr%0d", i, tbl[i].addr), d,
                       tbl[i].e0, tbl[i].e1, tbl[i].e2, tbl[i].e3);
        end

        // Read-first on a same-address collision, then hold when idle.
        do_write(9, 1'b0, 7);
        wr_en = 1'b1; wr_addr = 4'd9; acc_mode = 1'b0; set_psum(100, 100, 100, 100);
        do_read(9, d, v);
        wr_en = 1'b0;
        check_cols("rdfirst_old", d, 7, 7, 7, 7);
        do_read(9, d, v);
        check_cols("rdfirst_new", d, 100, 100, 100, 100);
        @(negedge clk);
        check("hold_valid", 128'(rd_valid), 128'(0));
        check_cols("hold_data", rd_data_flat, 100, 100, 100, 100);

        // Saturation at the positive rail.
        check("sat_before", 128'(sat_flags), 128'(0));
        wr_en = 1'b1; wr_addr = 4'd0; acc_mode = 1'b1;
        set_psum(262143, 262143, 262143, 262143);
        repeat (20) @(negedge clk);
        wr_en = 1'b0;
        check("sat_flags", 128'(sat_flags), 128'(4'b1111));
        do_read(0, d, v);
        check_cols("sat_value", d, 4194303, 4194303, 4194303, 4194303);

        // Clear resets flags; reads and a repeat start during the sweep are dropped.
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        check("clr_sat", 128'(sat_flags), 128'(0));
        cnt = 0;
        while (clear_busy && cnt < 40) begin
            cnt++;
            if (cnt == 4) check("clr_rd_drop", 128'(rd_valid), 128'(0));
            rd_en       = (cnt == 2 || cnt == 3);
            clear_start = (cnt == 3);
            @(negedge clk);
        end
        rd_en = 1'b0; clear_start = 1'b0;
        check("clr2_len", 128'(cnt), 128'(16));
        do_read(0, d, v);
        check_cols("clr2_addr0", d, 0, 0, 0, 0);

        // Reset during the sweep after words 0..4 are cleared.
        for (int a = 0; a < 6; a++) do_write(a, 1'b0, 85);
        do_read(2, d, v);
        check_cols("pre_abort", d, 85, 85, 85, 85);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 128'(clear_busy), 128'(0));
        check("abort_valid", 128'(rd_valid), 128'(0));
        check("abort_data", 128'(rd_data_flat), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        test_mode = 1'b0;
        @(negedge clk);
        for (int a = 0; a < 5; a++) begin
            do_read(a, d, v);
            check_cols($sformatf("abort_addr%0d", a), d, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
Output-side accumulator for the systolic array. It stores one partial-sum column memory per array column and de-skews the per-column write controls. In normal mode, column i sees wr_en/wr_addr/acc_mode delayed by i cycles. In test mode, all columns see them undelayed. Each write either overwrites or saturating-accumulates into the stored value. The block adds a hardware clear sequencer and a registered read port with a valid flag.

Parameters:
SYSTOLIC_SIZE, 8, number of columns (and skew depth - 1)
WEIGHT_WIDTH, 8, weight bit width
ACTIVATION_WIDTH, 8, activation bit width
PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+$clog2(SYSTOLIC_SIZE), signed input psum width
ACC_WIDTH, PARTIAL_SUM_WIDTH+4, signed stored word width (>= PARTIAL_SUM_WIDTH)
PATTERN_NUMBER, 4, tiles held per column
DEPTH, PATTERN_NUMBER*SYSTOLIC_SIZE, words per column
ADDR_WIDTH, $clog2(DEPTH), address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
test_mode  in  1  1 = bypass skew; all columns use column-0 controls
wr_en  in  1  column-0 write enable
wr_addr  in  ADDR_WIDTH  column-0 write address
acc_mode  in  1  1 = mem += psum (saturating), 0 = mem = sext(psum)
psum_in_flat  in  PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE  signed psums; column i at [i*PSW +: PSW]
clear_start  in  1  pulse; zero all words in all columns
clear_busy  out  1  high while clearing
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address (same for all columns)
rd_valid  out  1  rd_data_flat valid
rd_data_flat  out  ACC_WIDTH*SYSTOLIC_SIZE  column i at [i*ACC_WIDTH +: ACC_WIDTH]
sat_flags  out  SYSTOLIC_SIZE  sticky per-column saturation indicator

Behaviour:
- Skew pipeline: SYSTOLIC_SIZE-1 stages of {wr_en, wr_addr, acc_mode}; stage k feeds column k+1. The pipeline always shifts, regardless of test_mode.
- Column i controls: column 0 always uses the direct inputs. Column i>0 uses the direct inputs if test_mode=1, else pipeline stage i-1. The mux is combinational, so a test_mode toggle takes effect the same cycle.
- Column write at posedge when the effective wr_en=1 and clear_busy=0:
  - acc_mode=0: mem[a] <= sext(psum_i).
  - acc_mode=1: mem[a] <= sat(mem[a] + sext(psum_i)). sat clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. If clamping occurs, sat_flags[i] <= 1.
- Back-to-back accumulation to the same address must chain correctly with no bubble (mem read is combinational within the write cycle).
- Read: rd_data_flat and rd_valid are registered, 1-cycle latency. rd_valid = rd_en from the prior cycle, forced 0 while clear_busy.
  - A read and a write to the same address in the same cycle return the pre-write value (read-first).
  - rd_data_flat holds its last value when rd_valid=0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_start: counter <= 0, clear_busy <= 1.
  - In CLEAR, each cycle writes 0 at counter in all columns and increments the counter.
  - At counter == DEPTH-1, write that last word, then -> IDLE and clear_busy <= 0. The clear takes exactly DEPTH cycles.
  - Entering CLEAR resets sat_flags to 0.
  - clear_start while in CLEAR is ignored. Functional writes and reads during CLEAR are dropped, but skew stages keep shifting.
- Reset values: state IDLE, clear_busy 0, all skew stages 0 (en=0), rd_valid 0, rd_data_flat 0, sat_flags 0.
- Memory contents are not reset; software issues clear_start after reset.
- Reset mid-CLEAR aborts the clear immediately. The already-cleared words stay 0, and the rest are undefined.
- Address wrap: addresses >= DEPTH (non-power-of-2 DEPTH) are ignored for writes. Reads at such addresses return 0.

Decomposition:
- Package accumulator_pkg: width localparams (PSW, ACC_WIDTH defaults), the FSM state encoding (IDLE=0, CLEAR=1), and a function sat_add(acc, psum) returning the saturated sum and an overflow bit.
- Sub-module accumulator_column: one column's DEPTH x ACC_WIDTH memory, write/accumulate datapath, read-first registered read, and sticky sat flag.
- The top holds the skew pipeline, the test_mode mux, the clear FSM, and the generate loop over columns.

Test Plan:
- Bench parameters: SYSTOLIC_SIZE=4, ACC_WIDTH=23, DEPTH=16.
- Reset then clear_start -> clear_busy high exactly 16 cycles; reads of addr 0..15 return all-zero data with rd_valid one cycle after rd_en.
- Normal mode, wr_en=1 for one cycle at addr 3, acc_mode=0, psums {1,2,3,4} held 4 cycles -> column i written at cycle t+i; reading addr 3 returns {1,2,3,4}; addr 2 and addr 4 unchanged.
- test_mode=1, same stimulus -> all columns written in cycle t; reading addr 3 returns the column values present in cycle t.
- acc_mode=1, psum=+5 at addr 7 on 3 consecutive cycles (test_mode=1) -> addr 7 reads 15 in all columns; then psum=-20 accumulates to -5.
- Accumulate psum=max positive (2^18-1) repeatedly at addr 0 -> saturates at 2^22-1; sat_flags=4'b1111; a subsequent clear_start clears sat_flags.
- Assert rst_n low at cycle 5 of CLEAR -> clear_busy=0, rd_valid=0, skew enables 0 immediately; words 0..4 read 0 after release.
